// File: rtl/trdb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : trdb_stream_packer
// Description : Byte-aligned trace packet packer. Variable-length packets
//               (LSB-aligned, length in bits) are rounded up to whole bytes
//               and packed back-to-back into OUT_W-bit words, with the first
//               byte in the LSBs. Output has valid/ready backpressure. A flush
//               drains the buffer, zero-padding the final partial word, and
//               then pulses flush_confirm_o.
// Ports       : clk_i, rst_ni (async, active low)
//               packet_bits_i/packet_len_i/valid_i/grant_o : packet input
//               flush_i/flush_confirm_o                    : drain handshake
//               data_o/valid_o/ready_i                     : word output
// Config      : TRDB_SOURCE_TAG_EN - prefix each accepted packet with the
//               tag byte {3'b101, ID[4:0]}. Undefined: payload bytes only.
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_stream_packer #(
  parameter int PKT_W = 64,
  parameter int LEN_W = 7,
  parameter int OUT_W = 32,
  parameter int ID    = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PKT_W-1:0] packet_bits_i,
  input  logic [LEN_W-1:0] packet_len_i,
  input  logic             valid_i,
  output logic             grant_o,
  input  logic             flush_i,
  output logic             flush_confirm_o,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int OUT_B = OUT_W / 8;
  localparam int PKT_B = PKT_W / 8;
  localparam int BUF_B = OUT_B + PKT_B + 1;
  localparam int BUF_W = BUF_B * 8;
  localparam int FW    = $clog2(BUF_B + 1);
  localparam int INS_W = PKT_W + 8;

  localparam logic [FW-1:0] OUT_B_F  = FW'(OUT_B);
  localparam logic [7:0]    TAG_BYTE = {3'b101, 5'(ID)};

`ifdef TRDB_SOURCE_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             confirm_q, confirm_d;

  logic [PKT_W-1:0] w_pkt_masked;
  logic [INS_W-1:0] w_ins;
  logic [FW-1:0]    w_ins_bytes;
  logic [FW-1:0]    w_base_fill;
  logic [BUF_W-1:0] w_buf_base;
  logic             w_grant;
  logic             w_slot_free;
  logic             w_emit_full;
  logic             w_emit_part;

  // Keep only the first packet_len_i bits so the unused tail of the last
  // byte (and any bytes past it) enter the buffer as zeros.
  always_comb begin
    w_pkt_masked = '0;
    for (int i = 0; i < PKT_W; i++) begin
      if (i < int'(packet_len_i)) begin
        w_pkt_masked[i] = packet_bits_i[i];
      end
    end
  end

  assign w_ins       = TAG_EN ? {w_pkt_masked, TAG_BYTE} : {8'h00, w_pkt_masked};
  assign w_ins_bytes = FW'(packet_len_i >> 3) + FW'(|packet_len_i[2:0])
                     + (TAG_EN ? FW'(1) : FW'(0));

  assign w_grant     = valid_i && (state_q == S_RUN) && (fill_q < OUT_B_F);
  assign w_slot_free = !valid_q || ready_i;
  assign w_emit_full = (fill_q >= OUT_B_F) && w_slot_free;
  // Partial word only while flushing; bytes above fill are always zero,
  // which provides the MSB padding for free.
  assign w_emit_part = (state_q == S_FLUSH) && (fill_q != '0)
                     && (fill_q < OUT_B_F) && w_slot_free;

  always_comb begin
    w_base_fill = fill_q;
    w_buf_base  = buf_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready_i;
    if (w_emit_full || w_emit_part) begin
      data_d      = buf_q[OUT_W-1:0];
      valid_d     = 1'b1;
      w_buf_base  = buf_q >> OUT_W;
      w_base_fill = w_emit_full ? (fill_q - OUT_B_F) : '0;
    end
    // New bytes land just above whatever remains after an emit.
    buf_d  = w_buf_base;
    fill_d = w_base_fill;
    if (w_grant) begin
      buf_d  = w_buf_base | (BUF_W'(w_ins) << {w_base_fill, 3'b000});
      fill_d = w_base_fill + w_ins_bytes;
    end
  end

  always_comb begin
    state_d   = state_q;
    confirm_d = 1'b0;
    case (state_q)
      S_RUN: begin
        // A pending packet wins over a flush request.
        if (flush_i && !valid_i) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((fill_q == '0) && w_slot_free) begin
          state_d   = S_DONE;
          confirm_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_RUN;
      fill_q    <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      confirm_q <= confirm_d;
    end
  end

  assign grant_o         = w_grant;
  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign flush_confirm_o = confirm_q;

  always_ff @(posedge clk_i) begin
    if (rst_ni && valid_i) begin
      a_len_legal: assert ({{(32-LEN_W){1'b0}}, packet_len_i} <= PKT_W);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trdb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_stream_packer
// Description : Self-checking bench for trdb_stream_packer. A byte-queue
//               reference model turns every granted packet into expected
//               output words; the output monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_stream_packer;

  localparam int PKT_W = 64;
  localparam int LEN_W = 7;
  localparam int OUT_W = 32;
  localparam int ID    = 5;
  localparam int OUT_B = OUT_W / 8;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [PKT_W-1:0] packet_bits_i = '0;
  logic [LEN_W-1:0] packet_len_i = '0;
  logic             valid_i = 1'b0;
  logic             grant_o;
  logic             flush_i = 1'b0;
  logic             flush_confirm_o;
  logic [OUT_W-1:0] data_o;
  logic             valid_o;
  logic             ready_i = 1'b1;

  trdb_stream_packer #(
    .PKT_W(PKT_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .ID(ID)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .packet_bits_i  (packet_bits_i),
    .packet_len_i   (packet_len_i),
    .valid_i        (valid_i),
    .grant_o        (grant_o),
    .flush_i        (flush_i),
    .flush_confirm_o(flush_confirm_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [7:0]       mbytes[$];
  logic [OUT_W-1:0] exp_q[$];
  int               words_seen = 0;
  int               valid_cycles = 0;
  logic [OUT_W-1:0] last_word = '0;
  bit               rnd_ready = 1'b0;
  logic             ready_force = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_pkt(input logic [PKT_W-1:0] bits, input int len);
    int nb;
    logic [PKT_W-1:0] m;
    logic [OUT_W-1:0] w;
`ifdef TRDB_SOURCE_TAG_EN
    mbytes.push_back({3'b101, 5'(ID)});
`endif
    nb = (len + 7) / 8;
    for (int i = 0; i < PKT_W; i++) m[i] = (i < len) ? bits[i] : 1'b0;
    for (int b = 0; b < nb; b++) mbytes.push_back(m[8*b +: 8]);
    while (mbytes.size() >= OUT_B) begin
      for (int b = 0; b < OUT_B; b++) w[8*b +: 8] = mbytes.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_flush();
    logic [OUT_W-1:0] w;
    int n;
    n = mbytes.size();
    if (n > 0) begin
      w = '0;
      for (int b = 0; b < n; b++) w[8*b +: 8] = mbytes.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  // Single driver of ready_i; lags the active edge by 2 units so it never
  // races with the stimulus process (which works at +1).
  always @(posedge clk_i) begin
    #2;
    ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Output monitor: a word is transferred at the next edge when valid&&ready.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      valid_cycles++;
      if (ready_i) begin
        words_seen++;
        last_word = data_o;
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else                   chk("word", 64'(data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // Call with time at posedge+1; returns at posedge+1.
  task automatic send(input logic [PKT_W-1:0] bits, input int len);
    bit got;
    got = 1'b0;
    packet_bits_i = bits;
    packet_len_i  = LEN_W'(len);
    valid_i       = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_i);
      if (grant_o) begin
        got = 1'b1;
        model_pkt(bits, len);
      end
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!got) chk("grant_timeout", 64'(got), 64'd1);
  endtask

  task automatic flush_run();
    bit got;
    got = 1'b0;
    model_flush();
    flush_i = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_i);
      if (flush_confirm_o) begin
        got = 1'b1;
        flush_i = 1'b0;
      end
    end
    flush_i = 1'b0;
    chk("flush_confirm", 64'(got), 64'd1);
    @(negedge clk_i);
    chk("confirm_one_cycle", 64'(flush_confirm_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  int w0;
  int v0;

  initial begin
    // Reset state
    #12;
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_confirm", 64'(flush_confirm_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(2);

    // 1: reset with 3 bytes buffered drops them
`ifdef TRDB_SOURCE_TAG_EN
    send(64'hABCD, 16);
`else
    send(64'hABCDEF, 24);
`endif
    idle(1);
    rst_ni = 1'b0;
    mbytes.delete();
    exp_q.delete();
    #1;
    chk("mid_rst_data", 64'(data_o), 64'd0);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_grant", 64'(grant_o), 64'd0);
    chk("mid_rst_confirm", 64'(flush_confirm_o), 64'd0);
    idle(2);
    rst_ni = 1'b1;
    idle(1);
    w0 = words_seen;
    flush_run();
    idle(2);
    chk("t1_no_word", 64'(words_seen - w0), 64'd0);

    // 2: two 16-bit packets form one word
    w0 = words_seen;
    v0 = valid_cycles;
    send(64'hAAAA, 16);
    send(64'hBBBB, 16);
    idle(3);
    chk("t2_words", 64'(words_seen - w0), 64'd1);
    chk("t2_valid_cycles", 64'(valid_cycles - v0), 64'd1);
`ifndef TRDB_SOURCE_TAG_EN
    chk("t2_word", 64'(last_word), 64'hBBBBAAAA);
`endif
    flush_run();

    // 3: 12-bit packet then flush gives a padded word
    w0 = words_seen;
    send(64'h123, 12);
    flush_run();
    idle(1);
`ifndef TRDB_SOURCE_TAG_EN
    chk("t3_words", 64'(words_seen - w0), 64'd1);
    chk("t3_word", 64'(last_word), 64'h00000123);
`endif

    // 4: backpressure holds data_o and blocks grant
    ready_force = 1'b0;
    idle(1);
    w0 = words_seen;
    send(64'h1122334455667788, 64);
    idle(1);
    packet_bits_i = 64'h99;
    packet_len_i  = LEN_W'(8);
    valid_i       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("t4_grant_low", 64'(grant_o), 64'd0);
      chk("t4_valid_held", 64'(valid_o), 64'd1);
`ifndef TRDB_SOURCE_TAG_EN
      chk("t4_data_held", 64'(data_o), 64'h55667788);
`endif
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    ready_force = 1'b1;
    idle(4);
    chk("t4_words", 64'(words_seen - w0), 64'd2);
`ifndef TRDB_SOURCE_TAG_EN
    chk("t4_second", 64'(last_word), 64'h11223344);
`endif
    flush_run();

`ifdef TRDB_SOURCE_TAG_EN
    // 5: tag byte precedes the payload
    w0 = words_seen;
    send(64'hC0FFEE, 24);
    idle(3);
    chk("t5_words", 64'(words_seen - w0), 64'd1);
    chk("t5_word", 64'(last_word), 64'hC0FFEEA5);
    flush_run();
`endif

    // 6: valid_i has priority over flush_i; len 0 appends nothing
    w0 = words_seen;
    flush_i = 1'b1;
    send(64'h77, 8);
    flush_run();
    idle(1);
`ifndef TRDB_SOURCE_TAG_EN
    chk("t6_words", 64'(words_seen - w0), 64'd1);
    chk("t6_word", 64'(last_word), 64'h00000077);
    w0 = words_seen;
    send(64'hFFFF, 0);
    idle(3);
    chk("t6_len0_no_word", 64'(words_seen - w0), 64'd0);
    flush_run();
    idle(2);
    chk("t6_len0_flush_empty", 64'(words_seen - w0), 64'd0);
`endif

    // Random traffic with random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send({$urandom, $urandom}, int'($urandom_range(0, PKT_W)));
    end
    flush_run();
    rnd_ready = 1'b0;
    idle(4);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
